// File: rtl/step_decoder_seq_if.sv
// Bus bundle for step_decoder_seq: sequencing controls in, decoded step lines and status out.
interface step_decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic             Run;
  logic             Adv;
  logic             Clear;
  logic [SEL_W-1:0] Last;
  logic             Wrap;
  logic             En;
  logic [0:N-1]     Y;
  logic [SEL_W-1:0] Step;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, Adv, Clear, Last, Wrap, En,
    input  Y, Step, Busy, Done
  );

  modport slave (
    input  Run, Adv, Clear, Last, Wrap, En,
    output Y, Step, Busy, Done
  );
endinterface

// File: rtl/step_decoder_seq.sv
// Time-step sequencer: counts from 0 to a captured terminal step, decodes the count
// to one-hot step lines gated by En, and pulses Done after each terminal advance.
module step_decoder_seq #(
  parameter int SEL_W = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  step_decoder_seq_if.slave  bus
);
  localparam int N = 1 << SEL_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] step_q,  step_d;
  logic [SEL_W-1:0] last_q,  last_d;
  logic             done_q,  done_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (bus.Clear) begin
      state_d = IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Run) begin
            state_d = RUN;
            step_d  = '0;
            last_d  = bus.Last;
          end
        end
        RUN: begin
          if (bus.Adv) begin
            if (step_q == last_q) begin
              // Terminal advance: Wrap is sampled live here, not at start.
              step_d = '0;
              done_d = 1'b1;
              if (!bus.Wrap) state_d = IDLE;
            end else begin
              step_d = step_q + SEL_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.Y = '0;
    if (state_q == RUN && bus.En) bus.Y[step_q] = 1'b1;
  end

  assign bus.Step = step_q;
  assign bus.Busy = (state_q == RUN);
  assign bus.Done = done_q;
endmodule

// File: tb/tb_step_decoder_seq.sv
// Directed test of step_decoder_seq with SEL_W=3 and SEL_W=4 instances.
module tb_step_decoder_seq;
  logic Clock;
  logic Reset;
  int   checks;
  int   failures;

  step_decoder_seq_if #(.SEL_W(3)) a_if ();
  step_decoder_seq_if #(.SEL_W(4)) b_if ();

  step_decoder_seq #(.SEL_W(3)) dut_a (.Clock(Clock), .Reset(Reset), .bus(a_if.slave));
  step_decoder_seq #(.SEL_W(4)) dut_b (.Clock(Clock), .Reset(Reset), .bus(b_if.slave));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic busy, input logic [2:0] step,
                       input logic [7:0] y, input logic done);
    check({tag, ".busy"}, 32'(a_if.Busy), 32'(busy));
    check({tag, ".step"}, 32'(a_if.Step), 32'(step));
    check({tag, ".y"},    32'(a_if.Y),    32'(y));
    check({tag, ".done"}, 32'(a_if.Done), 32'(done));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    a_if.Run = 1'b1; a_if.Adv = 1'b1; a_if.Clear = 1'b0;
    a_if.Last = 3'd0; a_if.Wrap = 1'b0; a_if.En = 1'b1;
    b_if.Run = 1'b0; b_if.Adv = 1'b0; b_if.Clear = 1'b0;
    b_if.Last = 4'd0; b_if.Wrap = 1'b0; b_if.En = 1'b1;
    Reset = 1'b1;

    // 1: reset dominates Run/Adv
    tick(); chk_a("rst0", 1'b0, 3'd0, 8'b00000000, 1'b0);
    tick(); chk_a("rst1", 1'b0, 3'd0, 8'b00000000, 1'b0);
    Reset = 1'b0; a_if.Run = 1'b0; a_if.Adv = 1'b0;
    tick(); chk_a("idle", 1'b0, 3'd0, 8'b00000000, 1'b0);

    // 2: Last=3, no wrap, Adv held
    a_if.Last = 3'd3; a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0; a_if.Adv = 1'b1;
    chk_a("seq0", 1'b1, 3'd0, 8'b10000000, 1'b0);
    tick(); chk_a("seq1", 1'b1, 3'd1, 8'b01000000, 1'b0);
    tick(); chk_a("seq2", 1'b1, 3'd2, 8'b00100000, 1'b0);
    tick(); chk_a("seq3", 1'b1, 3'd3, 8'b00010000, 1'b0);
    tick(); a_if.Adv = 1'b0;
    chk_a("seqdone", 1'b0, 3'd0, 8'b00000000, 1'b1);
    tick(); chk_a("seqpost", 1'b0, 3'd0, 8'b00000000, 1'b0);

    // 3: Last=2, wrap loop, then drop Wrap at terminal step
    a_if.Last = 3'd2; a_if.Wrap = 1'b1; a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0; a_if.Adv = 1'b1;
    chk_a("wrap0", 1'b1, 3'd0, 8'b10000000, 1'b0);
    tick(); chk_a("wrap1", 1'b1, 3'd1, 8'b01000000, 1'b0);
    tick(); chk_a("wrap2", 1'b1, 3'd2, 8'b00100000, 1'b0);
    tick(); chk_a("wrap3", 1'b1, 3'd0, 8'b10000000, 1'b1);
    tick(); chk_a("wrap4", 1'b1, 3'd1, 8'b01000000, 1'b0);
    tick(); chk_a("wrap5", 1'b1, 3'd2, 8'b00100000, 1'b0);
    tick(); chk_a("wrap6", 1'b1, 3'd0, 8'b10000000, 1'b1);
    tick(); tick();
    chk_a("wrap8", 1'b1, 3'd2, 8'b00100000, 1'b0);
    a_if.Wrap = 1'b0;
    tick(); a_if.Adv = 1'b0;
    chk_a("wrapend", 1'b0, 3'd0, 8'b00000000, 1'b1);

    // 4: Clear mid-run beats Adv, then restart
    a_if.Last = 3'd5; a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0; a_if.Adv = 1'b1;
    tick(); tick(); tick();
    chk_a("clrpre", 1'b1, 3'd3, 8'b00010000, 1'b0);
    a_if.Clear = 1'b1;
    tick(); a_if.Clear = 1'b0; a_if.Adv = 1'b0;
    chk_a("clr", 1'b0, 3'd0, 8'b00000000, 1'b0);
    a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0;
    chk_a("restart", 1'b1, 3'd0, 8'b10000000, 1'b0);
    // Clear on the terminal-advance cycle suppresses Done
    a_if.Clear = 1'b1;
    tick(); a_if.Clear = 1'b0;
    a_if.Last = 3'd0; a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0; a_if.Adv = 1'b1; a_if.Clear = 1'b1;
    tick(); a_if.Adv = 1'b0; a_if.Clear = 1'b0;
    chk_a("clrterm", 1'b0, 3'd0, 8'b00000000, 1'b0);

    // 5: Run&Adv in IDLE, Last=0 single step; mid-run Last change ignored
    a_if.Last = 3'd0; a_if.Run = 1'b1; a_if.Adv = 1'b1;
    tick(); a_if.Run = 1'b0; a_if.Adv = 1'b0; a_if.Last = 3'd7;
    chk_a("runadv", 1'b1, 3'd0, 8'b10000000, 1'b0);
    a_if.Adv = 1'b1;
    tick(); a_if.Adv = 1'b0;
    chk_a("last0", 1'b0, 3'd0, 8'b00000000, 1'b1);

    // 6: En gating at Step=4; Run ignored while running
    a_if.Last = 3'd7; a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0; a_if.Adv = 1'b1;
    tick(); tick(); tick(); tick(); a_if.Adv = 1'b0;
    chk_a("en1", 1'b1, 3'd4, 8'b00001000, 1'b0);
    a_if.En = 1'b0; #1;
    chk_a("en0", 1'b1, 3'd4, 8'b00000000, 1'b0);
    a_if.Run = 1'b1;
    tick(); a_if.Run = 1'b0;
    chk_a("hold", 1'b1, 3'd4, 8'b00000000, 1'b0);
    a_if.En = 1'b1; #1;
    chk_a("en1b", 1'b1, 3'd4, 8'b00001000, 1'b0);
    a_if.Adv = 1'b1;
    tick(); tick(); tick();
    chk_a("full7", 1'b1, 3'd7, 8'b00000001, 1'b0);
    tick(); a_if.Adv = 1'b0;
    chk_a("fulldone", 1'b0, 3'd0, 8'b00000000, 1'b1);

    // SEL_W=4: full range to Y[15]
    b_if.Last = 4'd15; b_if.Run = 1'b1;
    tick(); b_if.Run = 1'b0; b_if.Adv = 1'b1;
    check("b.y0", 32'(b_if.Y), 32'h8000);
    for (int i = 0; i < 15; i++) tick();
    check("b.step15", 32'(b_if.Step), 32'd15);
    check("b.y15", 32'(b_if.Y), 32'h0001);
    check("b.busy15", 32'(b_if.Busy), 32'd1);
    tick(); b_if.Adv = 1'b0;
    check("b.done", 32'(b_if.Done), 32'd1);
    check("b.busyend", 32'(b_if.Busy), 32'd0);
    check("b.stepend", 32'(b_if.Step), 32'd0);
    tick();
    check("b.donepost", 32'(b_if.Done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_decoder_seq.md
Name: step_decoder_seq

Overview:
- Parametrised successor to the team's 3-to-8 one-hot decoder: a registered time-step sequencer whose count is decoded to a one-hot bus of 2^SEL_W lines.
- Drives the processor control unit's T0..Tn step lines: starts on Run, advances on Adv, terminates at a programmable last step, pulses Done.
- Supports an optional wrap (loop) mode and a combinational output enable with the same gating semantics as the existing decoder.

Parameters:
- SEL_W, 3, width of step count; number of outputs N = 2^SEL_W (derived localparam, not overridable).

Ports:
- Clock  in  1  single system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run    in  1  start request, honoured only in IDLE.
- Adv    in  1  advance one step, honoured only in RUN.
- Clear  in  1  synchronous abort to IDLE, no Done.
- Last   in  SEL_W  terminal step index, captured at start.
- Wrap   in  1  loop mode, sampled live at terminal advance.
- En     in  1  output enable, combinational gate on Y.
- Y      out [0:N-1]  one-hot step lines, Y[0] = step 0 (MSB-first indexing).
- Step   out SEL_W  current step count.
- Busy   out 1  high in RUN.
- Done   out 1  one-cycle completion pulse (registered).

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous, active-high, named Reset; clock port is Clock.
  - On Reset: state=IDLE, Step=0, LastQ=0, Busy=0, Done=0. Y is therefore all-zero.
- States: IDLE, RUN.
- Priority each cycle: Reset > Clear > Run/Adv.
- IDLE:
  - Run=1: next state RUN, Step=0, LastQ<=Last.
  - Adv is ignored, including Run&Adv in the same cycle; Step stays 0.
- RUN:
  - Adv=1 and Step!=LastQ: Step<=Step+1.
  - Adv=1 and Step==LastQ and Wrap=0: next state IDLE, Step<=0, Done<=1 for exactly one cycle.
  - Adv=1 and Step==LastQ and Wrap=1: stay in RUN, Step<=0, Done<=1 for one cycle (pulses once per loop).
  - Adv=0: hold.
  - Run is ignored while in RUN; Last changes mid-run have no effect.
- Clear=1 (any state): next state IDLE, Step=0, Done=0. Clear on the terminal-advance cycle suppresses Done.
- Last=0: a single-step sequence; the first Adv terminates it.
- Last=N-1: full range. Step never exceeds LastQ, so the counter cannot overflow or wrap through an unterminated state.
- Done is deasserted in every cycle other than the one following a terminal advance.
- Y is combinational from registered state:
  - Y[Step]=1, all others 0, iff Busy=1 and En=1.
  - Otherwise Y is all-zero.
  - En does not affect sequencing.
- Latency:
  - Y/Busy valid the cycle after Run.
  - Each Adv moves Y by one line on the next edge.
  - Done appears the cycle after the terminal Adv.

Test Plan:
1. Reset=1 for 2 cycles with Run=1, Adv=1 -> Busy=0, Step=0, Y=00000000, Done=0 throughout.
2. SEL_W=3, Last=3, Wrap=0, En=1; Run pulse, then Adv held high -> Y follows 10000000, 01000000, 00100000, 00010000 on consecutive cycles. Then Done=1 for one cycle, Busy=0, Y=00000000.
3. Last=2, Wrap=1, Adv held high for 7 cycles -> Step sequence 0,1,2,0,1,2,0 with Done pulsing after each 2->0 transition. Deassert Wrap while Step=2 and Adv=1 -> IDLE with Done=1.
4. Run with Last=5, advance to Step=3, then Clear=1 together with Adv=1 -> next cycle IDLE, Step=0, Done=0. A later Run restarts at Y=10000000.
5. Run&Adv in the same IDLE cycle with Last=0 -> Step=0, Busy=1. Next Adv -> Done=1, IDLE. Changing Last to 7 mid-run does not extend the sequence.
6. En toggled 1/0/1 during RUN at Step=4 -> Y alternates 00001000 / 00000000 / 00001000 while Step holds at 4. SEL_W=4 instance: Last=15 reaches Y[15]=1 with no overflow.
